// File: rtl/instr_loader_encoder.sv
// -----------------------------------------------------------------------------
// instr_loader_encoder
//
// Boot-time program loader. Accepts symbolic instruction fields over a
// valid/ready stream, packs them into 32-bit ARM words (ADD, SUB, AND, ORR,
// MOV, CMP, LDR, STR, B, BL, BX) and writes them sequentially into
// instruction memory. The processor is held in reset until an END token
// arrives.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : checksum_o is a running XOR of every word written
//   undefined : checksum_o is tied to zero, no XOR logic is built
//
// Parameters:
//   ADDR_W     instruction-memory word-address width (capacity 2^ADDR_W)
//   START_ADDR first word address written
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   in_valid_i     field bundle valid
//   in_ready_o     loader can accept a bundle
//   in_kind_i      0 ADD,1 SUB,2 AND,3 ORR,4 MOV,5 CMP,6 LDR,7 STR,8 B,9 BL,
//                  10 BX,15 END; 11-14 illegal
//   in_cond_i      condition field [31:28]
//   in_i_i         immediate-operand select (data processing)
//   in_s_i         S bit (data processing)
//   in_rd_i/in_rn_i/in_rm_i register fields
//   in_imm_i       imm12 in [11:0] for DP/memory, imm24 for branches
//   in_sh_i        shift type
//   in_shamt_i     shift amount
//   imem_we_o      instruction-memory write strobe
//   imem_addr_o    word address (holds last value when not writing)
//   imem_wdata_o   encoded instruction
//   cpu_reset_o    processor hold, high until loading completes
//   done_o         load finished (sticky until reset)
//   err_o          sticky error: illegal kind or overflow
//   checksum_o     running XOR of written words
// -----------------------------------------------------------------------------
module instr_loader_encoder #(
  parameter int ADDR_W     = 6,
  parameter int START_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_kind_i,
  input  logic [3:0]        in_cond_i,
  input  logic              in_i_i,
  input  logic              in_s_i,
  input  logic [3:0]        in_rd_i,
  input  logic [3:0]        in_rn_i,
  input  logic [3:0]        in_rm_i,
  input  logic [23:0]       in_imm_i,
  input  logic [1:0]        in_sh_i,
  input  logic [4:0]        in_shamt_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       checksum_o
);

  localparam logic [3:0] K_ADD = 4'd0;
  localparam logic [3:0] K_SUB = 4'd1;
  localparam logic [3:0] K_AND = 4'd2;
  localparam logic [3:0] K_ORR = 4'd3;
  localparam logic [3:0] K_MOV = 4'd4;
  localparam logic [3:0] K_CMP = 4'd5;
  localparam logic [3:0] K_LDR = 4'd6;
  localparam logic [3:0] K_STR = 4'd7;
  localparam logic [3:0] K_B   = 4'd8;
  localparam logic [3:0] K_BL  = 4'd9;
  localparam logic [3:0] K_BX  = 4'd10;
  localparam logic [3:0] K_END = 4'd15;

  localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic [31:0]       enc_s;
  logic              legal_s;

  // Kinds 11..14 are the only illegal codes; END (15) is legal.
  function automatic logic kind_legal(input logic [3:0] kind);
    kind_legal = (kind <= K_BX) || (kind == K_END);
  endfunction

  // Packs one field bundle into a 32-bit ARM instruction word.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  kind,
    input logic [3:0]  cond,
    input logic        imm_sel,
    input logic        s_bit,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [3:0]  rm,
    input logic [23:0] imm,
    input logic [1:0]  sh,
    input logic [4:0]  shamt
  );
    logic [3:0]  opc;
    logic [11:0] op2;
    logic [3:0]  rn_eff;
    logic [3:0]  rd_eff;
    logic        s_eff;
    op2    = imm_sel ? imm[11:0] : {shamt, sh, 1'b0, rm};
    rn_eff = rn;
    rd_eff = rd;
    s_eff  = s_bit;
    opc    = 4'b0000;
    encode_word = 32'h0000_0000;
    case (kind)
      K_ADD, K_SUB, K_AND, K_ORR, K_MOV, K_CMP: begin
        case (kind)
          K_ADD:   opc = 4'b0100;
          K_SUB:   opc = 4'b0010;
          K_AND:   opc = 4'b0000;
          K_ORR:   opc = 4'b1100;
          K_MOV:   opc = 4'b1101;
          K_CMP:   opc = 4'b1010;
          default: opc = 4'b0000;
        endcase
        // MOV has no first operand; CMP always sets flags and has no destination.
        if (kind == K_MOV) rn_eff = 4'd0;
        if (kind == K_CMP) begin
          s_eff  = 1'b1;
          rd_eff = 4'd0;
        end
        encode_word = {cond, 2'b00, imm_sel, opc, s_eff, rn_eff, rd_eff, op2};
      end
      K_LDR:   encode_word = {cond, 8'b0101_1001, rn, rd, imm[11:0]};
      K_STR:   encode_word = {cond, 8'b0101_1000, rn, rd, imm[11:0]};
      K_B:     encode_word = {cond, 4'b1010, imm};
      K_BL:    encode_word = {cond, 4'b1011, imm};
      K_BX:    encode_word = {cond, 24'h12FFF1, rm};
      default: encode_word = 32'h0000_0000;
    endcase
  endfunction

  assign enc_s   = encode_word(in_kind_i, in_cond_i, in_i_i, in_s_i, in_rd_i,
                               in_rn_i, in_rm_i, in_imm_i, in_sh_i, in_shamt_i);
  assign legal_s = kind_legal(in_kind_i);

  // Next-state logic. In ACCEPT the ready output is high (outside reset), so
  // a valid input is a transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid_i) begin
          if (in_kind_i == K_END) begin
            state_d = ST_DONE;
          end else if (!legal_s) begin
            err_d = 1'b1;
          end else if (full_q) begin
            // Program does not fit: flag it and stop loading.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            word_d  = enc_s;
            addr_d  = ptr_q;
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        // The pointer saturates at the last word; full marks it as consumed.
        if (ptr_q == PTR_MAX) begin
          full_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
        state_d = ST_ACCEPT;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_ACCEPT;
      ptr_q   <= START_PTR;
      full_q  <= 1'b0;
      addr_q  <= START_PTR;
      word_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from state only; reset gates ready while asserted.
  assign in_ready_o   = (state_q == ST_ACCEPT) && !reset_i;
  assign imem_we_o    = (state_q == ST_WRITE);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = word_q;
  assign cpu_reset_o  = (state_q != ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  // Fold each word into the checksum during its write cycle.
  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_WRITE) begin
      chk_d = chk_q ^ word_q;
    end else begin
      chk_d = chk_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      chk_q <= 32'h0000_0000;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum_o = chk_q;
`else
  assign checksum_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_loader_encoder.sv
module tb_instr_loader_encoder;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_kind, in_cond, in_rd, in_rn, in_rm;
  logic        in_i, in_s;
  logic [23:0] in_imm;
  logic [1:0]  in_sh;
  logic [4:0]  in_shamt;

  logic        rdy, we, cpu_rst, done, err;
  logic [5:0]  addr;
  logic [31:0] wdata, chk;

  logic        s_rdy, s_we, s_cpu_rst, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata, s_chk;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [1:0]  swa_q[$];
  logic [31:0] swd_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_loader_encoder #(.ADDR_W(6), .START_ADDR(0)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(rdy),
    .in_kind_i(in_kind), .in_cond_i(in_cond), .in_i_i(in_i), .in_s_i(in_s),
    .in_rd_i(in_rd), .in_rn_i(in_rn), .in_rm_i(in_rm), .in_imm_i(in_imm),
    .in_sh_i(in_sh), .in_shamt_i(in_shamt),
    .imem_we_o(we), .imem_addr_o(addr), .imem_wdata_o(wdata),
    .cpu_reset_o(cpu_rst), .done_o(done), .err_o(err), .checksum_o(chk)
  );

  instr_loader_encoder #(.ADDR_W(2), .START_ADDR(0)) dut_s (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(s_rdy),
    .in_kind_i(in_kind), .in_cond_i(in_cond), .in_i_i(in_i), .in_s_i(in_s),
    .in_rd_i(in_rd), .in_rn_i(in_rn), .in_rm_i(in_rm), .in_imm_i(in_imm),
    .in_sh_i(in_sh), .in_shamt_i(in_shamt),
    .imem_we_o(s_we), .imem_addr_o(s_addr), .imem_wdata_o(s_wdata),
    .cpu_reset_o(s_cpu_rst), .done_o(s_done), .err_o(s_err), .checksum_o(s_chk)
  );

  // Record every memory write seen by either instance.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(wdata);
    end
    if (s_we === 1'b1) begin
      swa_q.push_back(s_addr);
      swd_q.push_back(s_wdata);
    end
  end

  task automatic set_fields(input logic [3:0] k, input logic [3:0] c, input logic ii,
                            input logic ss, input logic [3:0] d, input logic [3:0] n,
                            input logic [3:0] m, input logic [23:0] im,
                            input logic [1:0] shf, input logic [4:0] sa);
    in_kind = k; in_cond = c; in_i = ii; in_s = ss; in_rd = d; in_rn = n;
    in_rm = m; in_imm = im; in_sh = shf; in_shamt = sa;
  endtask

  // Present a bundle at a negedge, wait (bounded) for ready, transfer it and
  // return at the negedge following the transfer edge.
  task automatic send(input logic [3:0] k, input logic [3:0] c, input logic ii,
                      input logic ss, input logic [3:0] d, input logic [3:0] n,
                      input logic [3:0] m, input logic [23:0] im,
                      input logic [1:0] shf, input logic [4:0] sa, input bit sm);
    bit got;
    got = 1'b0;
    set_fields(k, c, ii, ss, d, n, m, im, shf, sa);
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      if ((sm ? s_rdy : rdy) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout kind=%0d ready never seen, required ready=1", k);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    wa_q.delete(); wd_q.delete(); swa_q.delete(); swd_q.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    set_fields(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0);
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", rdy); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", we); end
    checks++; if (addr !== 6'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", addr); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", wdata); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", cpu_rst); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b want 00", done, err); end
    checks++; if (chk !== 32'h0) begin errors++; $display("FAIL rst_checksum got %h want 0", chk); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", rdy); end
    @(negedge clk);
  endtask

  task automatic test_add_end();
    do_reset();
    send(4'd0, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000005, 2'd0, 5'd0, 1'b0);
    checks++; if (we !== 1'b1 || addr !== 6'd0 || wdata !== 32'hE2821005) begin
      errors++; $display("FAIL add_write got we=%b addr=%0d data=%h want 1 0 e2821005", we, addr, wdata); end
    checks++; if (rdy !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++; $display("FAIL add_write_ctl got ready=%b cpu_reset=%b want 0 1", rdy, cpu_rst); end
    send(4'd15, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0, 1'b0);
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || rdy !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL end_done got done=%b cpu_reset=%b ready=%b we=%b want 1 0 0 0", done, cpu_rst, rdy, we); end
    @(negedge clk);
    checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL add_count got %0d want 1", wa_q.size()); end
    checks++; if (chk !== (CHK_EN ? 32'hE2821005 : 32'h0)) begin
      errors++; $display("FAIL add_checksum got %h want %h", chk, CHK_EN ? 32'hE2821005 : 32'h0); end
  endtask

  task automatic test_cmp_b_bx();
    logic [31:0] x;
    do_reset();
    // CMP r3,r4 with Rd and S deliberately wrong: encoder must force them.
    send(4'd5, 4'hE, 1'b0, 1'b0, 4'd7, 4'd3, 4'd4, 24'd0, 2'd0, 5'd0, 1'b0);
    send(4'd8, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 2'd0, 5'd0, 1'b0);
    send(4'd10, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd14, 24'd0, 2'd0, 5'd0, 1'b0);
    send(4'd15, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (wa_q.size() != 3) begin errors++; $display("FAIL cbx_count got %0d want 3", wa_q.size()); end
    checks++; if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'hE1530004) begin
      errors++; $display("FAIL cmp_word got addr=%0d data=%h want 0 e1530004", wa_q[0], wd_q[0]); end
    checks++; if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'h0AFFFFFE) begin
      errors++; $display("FAIL b_word got addr=%0d data=%h want 1 0afffffe", wa_q[1], wd_q[1]); end
    checks++; if (wa_q[2] !== 6'd2 || wd_q[2] !== 32'hE12FFF1E) begin
      errors++; $display("FAIL bx_word got addr=%0d data=%h want 2 e12fff1e", wa_q[2], wd_q[2]); end
    x = CHK_EN ? (32'hE1530004 ^ 32'h0AFFFFFE ^ 32'hE12FFF1E) : 32'h0;
    checks++; if (chk !== x) begin errors++; $display("FAIL cbx_checksum got %h want %h", chk, x); end
    checks++; if (addr !== 6'd2) begin errors++; $display("FAIL addr_hold got %0d want 2", addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_fields(4'd6, 4'hE, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000008, 2'd0, 5'd0);
    in_valid = 1'b1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", rdy); end
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_ready1 got %b want 0", rdy); end
    set_fields(4'd7, 4'hE, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h000008, 2'd0, 5'd0);
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b want 1", rdy); end
    @(negedge clk);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_ready3 got %b want 0", rdy); end
    // Illegal fields shown while not ready must be ignored.
    set_fields(4'd12, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0);
    #2;
    set_fields(4'd15, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", wa_q.size()); end
    checks++; if (wd_q[0] !== 32'hE5910008 || wa_q[0] !== 6'd0) begin
      errors++; $display("FAIL ldr_word got addr=%0d data=%h want 0 e5910008", wa_q[0], wd_q[0]); end
    checks++; if (wd_q[1] !== 32'hE5810008 || wa_q[1] !== 6'd1) begin
      errors++; $display("FAIL str_word got addr=%0d data=%h want 1 e5810008", wa_q[1], wd_q[1]); end
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_done got done=%b err=%b want 1 0", done, err); end
  endtask

  task automatic test_illegal();
    do_reset();
    send(4'd12, 4'hE, 1'b1, 1'b0, 4'd1, 4'd1, 4'd1, 24'h000123, 2'd0, 5'd0, 1'b0);
    checks++; if (err !== 1'b1 || we !== 1'b0 || rdy !== 1'b1) begin
      errors++; $display("FAIL illegal_state got err=%b we=%b ready=%b want 1 0 1", err, we, rdy); end
    // MOV with a nonzero Rn: encoder must clear it.
    send(4'd4, 4'hE, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 24'h000001, 2'd0, 5'd0, 1'b0);
    send(4'd15, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'hE3A00001) begin
      errors++; $display("FAIL mov_word got n=%0d addr=%0d data=%h want 1 0 e3a00001", wa_q.size(), wa_q[0], wd_q[0]); end
    checks++; if (err !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky got err=%b done=%b want 1 1", err, done); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int t = 0; t < 4; t++)
      send(4'd0, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'(t), 2'd0, 5'd0, 1'b1);
    checks++; if (s_err !== 1'b0 || s_done !== 1'b0) begin
      errors++; $display("FAIL ovf_pre got err=%b done=%b want 0 0", s_err, s_done); end
    send(4'd0, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'd4, 2'd0, 5'd0, 1'b1);
    checks++; if (s_err !== 1'b1 || s_done !== 1'b1 || s_we !== 1'b0 || s_cpu_rst !== 1'b0) begin
      errors++; $display("FAIL ovf_post got err=%b done=%b we=%b cpu_reset=%b want 1 1 0 0", s_err, s_done, s_we, s_cpu_rst); end
    @(negedge clk);
    checks++; if (swa_q.size() != 4) begin errors++; $display("FAIL ovf_count got %0d want 4", swa_q.size()); end
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (swa_q[t] !== 2'(t) || swd_q[t] !== (32'hE2821000 | 32'(t))) begin
        errors++; $display("FAIL ovf_word%0d got addr=%0d data=%h want %0d %h", t, swa_q[t], swd_q[t], t, 32'hE2821000 | 32'(t)); end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send(4'd0, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000001, 2'd0, 5'd0, 1'b0);
    send(4'd1, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000002, 2'd0, 5'd0, 1'b0);
    checks++; if (we !== 1'b1 || addr !== 6'd1) begin
      errors++; $display("FAIL mid_pre got we=%b addr=%0d want 1 1", we, addr); end
    reset = 1'b1;
    #1;
    checks++; if (we !== 1'b0 || cpu_rst !== 1'b1 || rdy !== 1'b0) begin
      errors++; $display("FAIL mid_abort got we=%b cpu_reset=%b ready=%b want 0 1 0", we, cpu_rst, rdy); end
    @(negedge clk);
    wa_q.delete(); wd_q.delete(); swa_q.delete(); swd_q.delete();
    reset = 1'b0;
    @(negedge clk);
    // ORR r3,r4,r5,LSR #3
    send(4'd3, 4'hE, 1'b0, 1'b0, 4'd3, 4'd4, 4'd5, 24'd0, 2'd1, 5'd3, 1'b0);
    send(4'd15, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'hE18431A5) begin
      errors++; $display("FAIL mid_restart got n=%0d addr=%0d data=%h want 1 0 e18431a5", wa_q.size(), wa_q[0], wd_q[0]); end
    checks++; if (chk !== (CHK_EN ? 32'hE18431A5 : 32'h0)) begin
      errors++; $display("FAIL mid_checksum got %h want %h", chk, CHK_EN ? 32'hE18431A5 : 32'h0); end
  endtask

  initial begin
    test_reset();
    test_add_end();
    test_cmp_b_bx();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader_encoder.md
# instr_loader_encoder

Boot-time program loader that is the encoding counterpart of the core's instruction decoder. It accepts symbolic instruction fields over a valid/ready stream and packs them into 32-bit ARM words for the subset the control unit decodes: ADD, SUB, AND, ORR, MOV, CMP, LDR, STR, B, BL and BX. It writes the words sequentially into instruction memory and holds the processor in reset until an END token arrives.

## Interface
- ADDR_W, 6: instruction-memory word-address width; capacity 2^ADDR_W words
- START_ADDR, 0: first word address written
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 MOV, 5 CMP, 6 LDR, 7 STR, 8 B, 9 BL, 10 BX, 15 END; 11–14 illegal
- in_cond  in  4  condition field, placed in [31:28]
- in_i  in  1  immediate-operand select for data-processing instructions
- in_s  in  1  S bit for data-processing instructions
- in_rd, in_rn, in_rm  in  4 each  register fields
- in_imm  in  24  imm12 in [11:0] for DP/memory; imm24 for branch
- in_sh  in  2  shift type; in_shamt  in  5  shift amount
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- cpu_reset  out  1  processor hold; high until load completes
- done  out  1  load finished (sticky until reset)
- err  out  1  sticky error: illegal kind or overflow
- checksum  out  32  running XOR of written words (see Configuration)

## Operation
- States: ACCEPT, WRITE, DONE. Reset enters ACCEPT.
- ACCEPT: in_ready=1. Transfer occurs on a rising edge where in_valid&in_ready.
  - Legal, non-END kind, memory not full: register the encoded word and go to WRITE.
  - Kind 11–14: discard the bundle, set err, stay in ACCEPT.
  - END: go to DONE with no write.
  - Non-END kind while full: set err, discard the bundle, go to DONE.
- WRITE: in_ready=0. imem_we=1, imem_addr=ptr, imem_wdata=word. Then ptr increments. If ptr was 2^ADDR_W−1, set full (ptr does not wrap). Return to ACCEPT.
- DONE: in_ready=0, cpu_reset=0, done=1. Terminal until reset.
- Encodings:
  - Data-processing: {cond,00,I,opc,S,Rn,Rd,op2}. opc values: ADD 0100, SUB 0010, AND 0000, ORR 1100, MOV 1101 (Rn forced 0), CMP 1010 (S forced 1, Rd forced 0).
  - op2: I=1 gives in_imm[11:0]; I=0 gives {shamt,sh,0,Rm}.
  - LDR: {cond,0101_1001,Rn,Rd,imm12}. STR: {cond,0101_1000,Rn,Rd,imm12}.
  - B: {cond,1010,imm24}. BL: {cond,1011,imm24}.
  - BX: {cond,0001_0010_1111_1111_1111_0001,Rm}; bits [27:4] equal 24'h12FFF1.

## Timing
- Asynchronous reset values: state ACCEPT, ptr=START_ADDR, full=0.
  - in_ready=0 while reset is asserted, then 1.
  - imem_we=0, imem_addr=START_ADDR, imem_wdata=0, cpu_reset=1, done=0, err=0, checksum=0.
- Write latency: a bundle accepted at edge N appears as imem_we=1 during cycle N+1. Peak throughput is one word every two cycles.
- END accepted at edge N: done=1 and cpu_reset=0 from cycle N+1.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- imem_addr holds its last value when imem_we=0.
- Reset mid-WRITE aborts the write: imem_we drops asynchronously and loading restarts at START_ADDR.
- Changing in_* while in_valid=1 and in_ready=0 has no effect.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum is updated to checksum^imem_wdata on every WRITE cycle and is stable from the cycle done rises.
- Undefined: checksum is tied to 0 and no XOR logic is synthesised. All other behaviour is identical.

## Test plan
- ADD r1,r2,#5 (cond E, I=1, imm 0x005) then END -> one write, addr 0, data 0xE2821005. Next cycle done=1, cpu_reset=0.
- CMP r3,r4 (cond E, I=0), B with imm24 0xFFFFFE (cond 0), BX r14 -> words 0xE1530004, 0x0AFFFFFE, 0xE12FFF1E at addrs 0,1,2.
- LDR r0,[r1,#8] and STR r0,[r1,#8] -> 0xE5910008 and 0xE5810008. Bench holds in_valid high continuously; in_ready must toggle 1,0,1,0.
- Kind 12, then MOV r0,#1 -> err=1, first bundle discarded, 0xE3A00001 written at addr 0.
- ADDR_W=2: five legal bundles -> four writes at addrs 0–3, fifth bundle sets err=1 and done=1, no write.
- Reset asserted during a WRITE cycle -> imem_we=0 and cpu_reset=1 immediately. After release, the next bundle is written at START_ADDR. With LOADER_CHECKSUM_EN, checksum restarts at 0.
